// File: rtl/host_ptr_tracker_if.sv
// Request channel from the pointer tracker to the DMA read engine.
// Master drives a ring-index/length pair under valid; slave accepts with ready.
interface host_ptr_tracker_if #(
  parameter int AW = 10,
  parameter int LW = 5
);
  logic          req_valid;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_len;
  logic          req_ready;

  modport master (
    output req_valid,
    output req_addr,
    output req_len,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_len,
    output req_ready
  );
endinterface

// File: rtl/host_ptr_tracker.sv
// Turns producer-pointer advances into read requests of at most MAX_BURST entries, split at the ring end.
// Request valid two cycles after a pointer change is seen in IDLE; a stalled request holds until ready.
module host_ptr_tracker #(
  parameter int AW        = 10,
  parameter int MAX_BURST = 16,
  parameter int LW        = $clog2(MAX_BURST) + 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [AW-1:0]         i_sync_ptr,
  host_ptr_tracker_if.master    req_if,
  output logic [AW-1:0]         o_rd_ptr,
  output logic                  o_busy
);

  localparam logic [AW:0] DEPTH_EXT = (AW + 1)'(1 << AW);
  localparam logic [AW:0] MAXB_EXT  = (AW + 1)'(MAX_BURST);

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_CALC = 3'b010,
    S_REQ  = 3'b100
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_req_addr;
  logic [LW-1:0] r_req_len;
  logic          r_req_valid;

  logic [AW-1:0] w_avail;
  logic [AW:0]   w_to_end;
  logic [AW:0]   w_len_full;
  logic [LW-1:0] w_len;
  logic          w_load;
  logic          w_accept;

  // Natural AW-bit wrap gives the ring occupancy; to_end is one bit wider so rd_ptr=0 yields DEPTH.
  assign w_avail  = i_sync_ptr - r_rd_ptr;
  assign w_to_end = DEPTH_EXT - {1'b0, r_rd_ptr};

  always_comb begin
    w_len_full = {1'b0, w_avail};
    if (MAXB_EXT < w_len_full) begin
      w_len_full = MAXB_EXT;
    end
    if (w_to_end < w_len_full) begin
      w_len_full = w_to_end;
    end
  end

  assign w_len = LW'(w_len_full);

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_en && (i_sync_ptr != r_rd_ptr)) begin
          w_state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        // A zero-length result can only come from a pointer glitch; fall back rather than issue it.
        if (w_len_full != '0) begin
          w_state_nxt = S_REQ;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_REQ: begin
        if (req_if.req_ready) begin
          w_state_nxt = S_IDLE;
          w_accept    = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_ptr    <= '0;
      r_req_addr  <= '0;
      r_req_len   <= '0;
      r_req_valid <= 1'b0;
    end else begin
      r_req_valid <= (w_state_nxt == S_REQ);
      if (w_load) begin
        r_req_addr <= r_rd_ptr;
        r_req_len  <= w_len;
      end
      if (w_accept) begin
        r_rd_ptr <= r_rd_ptr + AW'(r_req_len);
      end
    end
  end

  assign req_if.req_valid = r_req_valid;
  assign req_if.req_addr  = r_req_addr;
  assign req_if.req_len   = r_req_len;
  assign o_rd_ptr         = r_rd_ptr;
  assign o_busy           = (r_state != S_IDLE);

endmodule

// File: tb/tb_host_ptr_tracker.sv
// Directed scenarios plus a randomized run against a ring-arithmetic reference model.
module tb_host_ptr_tracker;

  localparam int AW    = 4;
  localparam int MB    = 4;
  localparam int LW    = 3;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [AW-1:0] sync_ptr;
  logic [AW-1:0] rd_ptr;
  logic          busy;

  host_ptr_tracker_if #(.AW(AW), .LW(LW)) req_if ();

  host_ptr_tracker #(.AW(AW), .MAX_BURST(MB), .LW(LW)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_en       (en),
    .i_sync_ptr (sync_ptr),
    .req_if     (req_if),
    .o_rd_ptr   (rd_ptr),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_len(input int sp, input int rp);
    int m;
    m = (sp - rp) & (DEPTH - 1);
    if (MB < m) m = MB;
    if (DEPTH - rp < m) m = DEPTH - rp;
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_if.req_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int w;
    w = 0;
    while (!req_if.req_valid && w < 20) begin
      tick();
      w++;
    end
    check_eq({tag, "_valid"}, 32'(req_if.req_valid), 1);
  endtask

  // Waits (bounded) for a request, checks it, accepts it in one cycle.
  task automatic take_req(input string tag, input int ea, input int el, input int ewait);
    int w;
    w = 0;
    req_if.req_ready = 1'b1;
    while (!req_if.req_valid && w < 20) begin
      tick();
      w++;
    end
    check_eq({tag, "_valid"}, 32'(req_if.req_valid), 1);
    if (ewait >= 0) check_eq({tag, "_wait"}, 32'(w), 32'(ewait));
    check_eq({tag, "_addr"}, 32'(req_if.req_addr), 32'(ea));
    check_eq({tag, "_len"}, 32'(req_if.req_len), 32'(el));
    check_eq({tag, "_inring"}, 32'((int'(req_if.req_addr) + int'(req_if.req_len)) <= DEPTH), 1);
    tick();
    check_eq({tag, "_drop"}, 32'(req_if.req_valid), 0);
    check_eq({tag, "_rdptr"}, 32'(rd_ptr), 32'((ea + el) % DEPTH));
    req_if.req_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int model_rd, host, occ, adv, n_acc, held_a, held_l, el;
    logic pv, pr;

    rst = 1'b1;
    en = 1'b1;
    sync_ptr = 4'd5;
    req_if.req_ready = 1'b0;

    // Reset held with a pending pointer: everything zero, then first request two cycles after release.
    repeat (3) tick();
    check_eq("rst_valid", 32'(req_if.req_valid), 0);
    check_eq("rst_addr", 32'(req_if.req_addr), 0);
    check_eq("rst_len", 32'(req_if.req_len), 0);
    check_eq("rst_rdptr", 32'(rd_ptr), 0);
    check_eq("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    take_req("rst_first", 0, 4, 2);
    take_req("rst_second", 4, 1, 2);
    tick();
    check_eq("rst_idle", 32'(busy), 0);

    sync_ptr = '0;
    do_reset();
    sync_ptr = 4'd3;
    take_req("simple", 0, 3, 2);
    tick();
    check_eq("simple_idle", 32'(busy), 0);

    sync_ptr = 4'd12;
    take_req("split0", 3, 4, 2);
    take_req("split1", 7, 4, 2);
    take_req("split2", 11, 1, 2);

    sync_ptr = 4'd14;
    take_req("wrap_pre", 12, 2, 2);
    sync_ptr = 4'd2;
    take_req("wrap0", 14, 2, 2);
    take_req("wrap1", 0, 2, 2);

    // Backpressure with the pointer moving mid-stall.
    sync_ptr = '0;
    do_reset();
    sync_ptr = 4'd4;
    wait_valid("bp_first");
    for (int i = 0; i < 5; i++) begin
      if (i == 1) sync_ptr = 4'd9;
      tick();
      check_eq("bp_hold_valid", 32'(req_if.req_valid), 1);
      check_eq("bp_hold_addr", 32'(req_if.req_addr), 0);
      check_eq("bp_hold_len", 32'(req_if.req_len), 4);
    end
    take_req("bp0", 0, 4, 0);
    take_req("bp1", 4, 4, 2);
    take_req("bp2", 8, 1, 2);

    // Enable and reset interplay.
    sync_ptr = '0;
    do_reset();
    en = 1'b0;
    sync_ptr = 4'd3;
    repeat (6) tick();
    check_eq("en_off_valid", 32'(req_if.req_valid), 0);
    check_eq("en_off_busy", 32'(busy), 0);
    en = 1'b1;
    wait_valid("en_on");
    en = 1'b0;
    repeat (2) tick();
    check_eq("en_drop_hold", 32'(req_if.req_valid), 1);
    take_req("en_drop", 0, 3, 0);
    sync_ptr = 4'd6;
    repeat (4) tick();
    check_eq("en_off2_valid", 32'(req_if.req_valid), 0);
    check_eq("en_off2_busy", 32'(busy), 0);
    en = 1'b1;
    wait_valid("rst_mid");
    check_eq("rst_mid_addr", 32'(req_if.req_addr), 3);
    check_eq("rst_mid_len", 32'(req_if.req_len), 3);
    rst = 1'b1;
    tick();
    check_eq("rst_mid_valid", 32'(req_if.req_valid), 0);
    check_eq("rst_mid_rdptr", 32'(rd_ptr), 0);
    check_eq("rst_mid_busy", 32'(busy), 0);
    rst = 1'b0;

    // Randomized run: host only ever advances, never more than DEPTH-1 ahead of consumed entries.
    sync_ptr = '0;
    en = 1'b1;
    do_reset();
    model_rd = 0;
    host = 0;
    n_acc = 0;
    held_a = 0;
    held_l = 0;
    pv = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      req_if.req_ready = ($urandom % 4) != 0;
      en = ($urandom % 8) != 0;
      if ($urandom % 5 == 0) begin
        occ = (host - model_rd) & (DEPTH - 1);
        adv = int'($urandom_range(0, 15 - occ));
        host = (host + adv) & (DEPTH - 1);
        sync_ptr = AW'(host);
      end
      pr = req_if.req_ready;
      tick();
      if (pv && pr) begin
        model_rd = (model_rd + held_l) % DEPTH;
        n_acc++;
        check_eq("rnd_rdptr", 32'(rd_ptr), 32'(model_rd));
        check_eq("rnd_drop", 32'(req_if.req_valid), 0);
      end else if (pv) begin
        check_eq("rnd_stall_valid", 32'(req_if.req_valid), 1);
        check_eq("rnd_stall_addr", 32'(req_if.req_addr), 32'(held_a));
        check_eq("rnd_stall_len", 32'(req_if.req_len), 32'(held_l));
      end else if (req_if.req_valid) begin
        el = exp_len(int'(sync_ptr), model_rd);
        check_eq("rnd_addr", 32'(req_if.req_addr), 32'(model_rd));
        check_eq("rnd_len", 32'(req_if.req_len), 32'(el));
        check_eq("rnd_inring", 32'((int'(req_if.req_addr) + int'(req_if.req_len)) <= DEPTH), 1);
        held_a = model_rd;
        held_l = el;
      end
      pv = req_if.req_valid;
    end
    check_eq("rnd_progress", 32'(n_acc > 10), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
